// File: rtl/mix_columns_engine.sv
// mix_columns_engine: AES MixColumns / InvMixColumns over a 128-bit state,
// transforming COLS_PER_CYCLE columns per clock. The mode is latched per block.
// Latency: accept at edge k -> out_valid after edge k+N_STEPS (N_STEPS = 4/COLS_PER_CYCLE).
// Backpressure: DONE holds out_data stable until out_ready; in_ready = out_ready in DONE.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data[127:0]/in_inverse;
//        out_valid/out_ready/out_data[127:0]; busy (high in BUSY).
// Layout: column c = bits [32c+31:32c], row 0 is the top byte of the column.
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inverse,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int         N_STEPS  = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] CNT_LAST = 2'(N_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [127:0]  data_q;
  logic [127:0]  data_step;
  logic          mode_q;
  logic [1:0]    cnt_q;
  logic          load;
  logic          step;

  // GF(2^8) multiply by 2 with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One column transform. Each output row uses the same coefficient set,
  // rotated right by the row index.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0]  a  [4];
    logic [7:0]  m2 [4];
    logic [7:0]  m3 [4];
    logic [7:0]  m9 [4];
    logic [7:0]  mb [4];
    logic [7:0]  md [4];
    logic [7:0]  me [4];
    logic [7:0]  x2, x4, x8;
    logic [31:0] res;
    res = 32'h0;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[8*(3-r) +: 8];
      x2    = xtime(a[r]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m2[r] = x2;
      m3[r] = x2 ^ a[r];
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    for (int r = 0; r < 4; r++) begin
      if (inv) begin
        res[8*(3-r) +: 8] = me[2'(r)] ^ mb[2'(r+1)] ^ md[2'(r+2)] ^ m9[2'(r+3)];
      end else begin
        res[8*(3-r) +: 8] = m2[2'(r)] ^ m3[2'(r+1)] ^ a[2'(r+2)] ^ a[2'(r+3)];
      end
    end
    return res;
  endfunction

  // Columns whose group index (j / COLS_PER_CYCLE) matches cnt are
  // transformed this step; all others pass through unchanged.
  always_comb begin
    data_step = data_q;
    for (int j = 0; j < 4; j++) begin
      if (2'(j / COLS_PER_CYCLE) == cnt_q) begin
        data_step[32*j +: 32] = mix_col(data_q[32*j +: 32], mode_q);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            // Output drains and the next block loads on the same edge.
            load    = 1'b1;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= 128'h0;
      mode_q  <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      if (load) begin
        data_q <= in_data;
        mode_q <= in_inverse;
        cnt_q  <= 2'd0;
      end else if (step) begin
        data_q <= data_step;
        cnt_q  <= cnt_q + 2'd1;
      end
    end
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// tb_mix_columns_engine: directed stimulus against three engine instances
// (COLS_PER_CYCLE = 1, 2, 4) with an expected-result queue checked on output.
// Index k selects the instance; N_STEPS for instance k is 4 >> k.
module tb_mix_columns_engine;

  logic         clk;
  logic         rst_n;
  logic         iv    [3];
  logic         irdy  [3];
  logic [127:0] idat  [3];
  logic         iinv  [3];
  logic         ov    [3];
  logic         ordy  [3];
  logic [127:0] od    [3];
  logic         bz    [3];
  logic         ov_prev [3];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct packed {
    int           k;
    int           due;
    logic [127:0] d;
  } sb_t;
  sb_t sbq[$];

  localparam logic [127:0] FWD_IN  = {32'hc6c6c6c6, 32'h01010101, 32'hf20a225c, 32'hdb135345};
  localparam logic [127:0] FWD_OUT = {32'hc6c6c6c6, 32'h01010101, 32'h9fdc589d, 32'h8e4da1bc};
  localparam logic [127:0] P_BLK   = {32'hd4d4d4d5, 32'h2d26314c, 32'hd4d4d4d5, 32'h2d26314c};
  localparam logic [127:0] Q_BLK   = {32'hd5d5d7d6, 32'h4d7ebdf8, 32'hd5d5d7d6, 32'h4d7ebdf8};

  genvar g;
  for (g = 0; g < 3; g++) begin : g_dut
    mix_columns_engine #(.COLS_PER_CYCLE(1 << g)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (iv[g]),
      .in_ready   (irdy[g]),
      .in_data    (idat[g]),
      .in_inverse (iinv[g]),
      .out_valid  (ov[g]),
      .out_ready  (ordy[g]),
      .out_data   (od[g]),
      .busy       (bz[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference GF(2^8) multiply (shift-and-add).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [7:0]   cf [4];
    logic [7:0]   a  [4];
    logic [7:0]   acc;
    logic [127:0] r = 128'h0;
    cf[0] = inv ? 8'h0e : 8'h02;
    cf[1] = inv ? 8'h0b : 8'h03;
    cf[2] = inv ? 8'h0d : 8'h01;
    cf[3] = inv ? 8'h09 : 8'h01;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = s[32*c + 8*(3-i) +: 8];
      for (int row = 0; row < 4; row++) begin
        acc = 8'h0;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(cf[(j - row + 4) % 4], a[j]);
        r[32*c + 8*(3-row) +: 8] = acc;
      end
    end
    return r;
  endfunction

  // Output monitor: latency on the rising edge of out_valid, data on transfer.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ov[k] && !ov_prev[k]) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out_valid", 128'(ov[k]), 128'(0));
        end else begin
          chk("sb_dut", 128'(k), 128'(sbq[0].k));
          chk("latency", 128'(cyc), 128'(sbq[0].due));
        end
      end
      if (ov[k] && ordy[k] && sbq.size() > 0) begin
        chk("out_data", od[k], sbq[0].d);
        sbq.pop_front();
      end
      ov_prev[k] = ov[k];
    end
  end

  // Called #1 after a rising edge. Returns #1 after the accepting edge.
  task automatic send(input int k, input logic [127:0] d, input logic inv,
                      input logic [127:0] exp, output int acc);
    bit   done = 0;
    sb_t  e;
    acc = -1;
    iv[k] = 1'b1; idat[k] = d; iinv[k] = inv;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (irdy[k]) begin
        acc   = cyc + 1;
        e.k   = k;
        e.due = acc + (4 >> k);
        e.d   = exp;
        sbq.push_back(e);
        done  = 1;
      end
    end
    if (!done) chk("accept_timeout", 128'(0), 128'(1));
    @(posedge clk); #1;
    iv[k] = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (sbq.size() != 0) begin
      chk("drain_timeout", 128'(sbq.size()), 128'(0));
      sbq.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, prev, nbusy, nvld;
    logic [127:0] r, ea, bb;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; idat[k] = '0; iinv[k] = 1'b0; ordy[k] = 1'b1; ov_prev[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", 128'(irdy[k]), 128'(1));
      chk("rst_out_valid", 128'(ov[k]), 128'(0));
      chk("rst_busy", 128'(bz[k]), 128'(0));
      chk("rst_out_data", od[k], 128'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Forward vector, one column per cycle; busy for exactly 4 cycles.
    send(0, FWD_IN, 1'b0, FWD_OUT, acc);
    nbusy = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (bz[0]) nbusy++;
    end
    chk("busy_cycles", 128'(nbusy), 128'(4));
    chk("model_fwd_vector", model(FWD_IN, 1'b0), FWD_OUT);
    @(posedge clk); #1;
    drain();

    // Inverse returns the original on every width.
    for (int k = 0; k < 3; k++) begin
      send(k, FWD_OUT, 1'b1, FWD_IN, acc);
      drain();
    end

    // Back-to-back, alternating modes, out_ready held high.
    for (int k = 0; k < 3; k++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      send(k, P_BLK, 1'b0, Q_BLK, prev);
      send(k, Q_BLK, 1'b1, P_BLK, acc);
      chk("b2b_spacing", 128'(acc - prev), 128'((4 >> k) + 1));
      prev = acc;
      send(k, r, 1'b0, model(r, 1'b0), acc);
      chk("b2b_spacing", 128'(acc - prev), 128'((4 >> k) + 1));
      prev = acc;
      send(k, r, 1'b1, model(r, 1'b1), acc);
      chk("b2b_spacing", 128'(acc - prev), 128'((4 >> k) + 1));
      drain();
    end

    // Backpressure: DONE held 10 cycles with a pending block.
    ea = {$urandom, $urandom, $urandom, $urandom};
    bb = {$urandom, $urandom, $urandom, $urandom};
    ordy[0] = 1'b0;
    send(0, ea, 1'b0, model(ea, 1'b0), acc);
    iv[0] = 1'b1; idat[0] = bb; iinv[0] = 1'b1;
    for (int t = 0; t < 20 && !ov[0]; t++) @(negedge clk);
    chk("bp_reach_done", 128'(ov[0]), 128'(1));
    for (int t = 0; t < 10; t++) begin
      chk("bp_hold_data", od[0], model(ea, 1'b0));
      chk("bp_in_ready", 128'(irdy[0]), 128'(0));
      @(negedge clk);
    end
    @(posedge clk); #1;
    ordy[0] = 1'b1;
    begin
      sb_t e;
      @(negedge clk);
      chk("bp_release_in_ready", 128'(irdy[0]), 128'(1));
      e.k = 0; e.due = cyc + 1 + 4; e.d = model(bb, 1'b1);
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    drain();

    // Mode toggling during BUSY has no effect.
    r = {$urandom, $urandom, $urandom, $urandom};
    send(0, r, 1'b0, model(r, 1'b0), acc);
    for (int t = 0; t < 5; t++) begin iinv[0] = ~iinv[0]; @(posedge clk); #1; end
    drain();
    send(0, r, 1'b1, model(r, 1'b1), acc);
    for (int t = 0; t < 5; t++) begin iinv[0] = ~iinv[0]; @(posedge clk); #1; end
    drain();

    // Reset mid-BUSY at cnt = 2: block discarded, outputs clear at once.
    send(0, P_BLK, 1'b0, Q_BLK, acc);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("midrst_out_valid", 128'(ov[0]), 128'(0));
    chk("midrst_in_ready", 128'(irdy[0]), 128'(1));
    chk("midrst_out_data", od[0], 128'h0);
    chk("midrst_busy", 128'(bz[0]), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    nvld = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (ov[0]) nvld++;
    end
    chk("midrst_no_output", 128'(nvld), 128'(0));
    @(posedge clk); #1;
    send(0, P_BLK, 1'b0, Q_BLK, acc);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
